// File: rtl/onewire_bus_master_pkg.sv
// rtl/onewire_bus_master_pkg.sv - shared state encodings and default timing for the 1-Wire master
// Purpose: FSM state type, us-counter width and default timing constants
//          used by onewire_bus_master and onewire_us_timer.
// Ports:   none (package).
package onewire_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_WAIT = 3'd2,
    ST_RST_REC  = 3'd3,
    ST_SLOT_LOW = 3'd4,
    ST_SLOT_REL = 3'd5,
    ST_NEXT     = 3'd6
  } state_e;

  localparam int US_CNT_W = 10;
  localparam logic [US_CNT_W-1:0] US_CNT_MAX = '1;

  localparam int DEF_TICKS_PER_US = 25;
  localparam int DEF_T_RST_LOW    = 480;
  localparam int DEF_T_PRES_SMP   = 70;
  localparam int DEF_T_RST_TOTAL  = 480;
  localparam int DEF_T_SLOT       = 70;
  localparam int DEF_T_W1_LOW     = 6;
  localparam int DEF_T_W0_LOW     = 60;
  localparam int DEF_T_RD_SMP     = 15;

endpackage

// File: rtl/onewire_us_timer.sv
// rtl/onewire_us_timer.sv - microsecond prescaler and saturating us counter
// Purpose: divides clk by TICKS_PER_US into a 1-cycle us_tick and counts
//          elapsed microseconds since the last clear; the count saturates.
// Ports:   clk, n_rst (async, active low), clear_i (restart prescaler and
//          counter), us_tick_o (last clk of each us), us_cnt_o (elapsed us).
module onewire_us_timer
  import onewire_bus_master_pkg::*;
#(
  parameter int TICKS_PER_US = DEF_TICKS_PER_US
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear_i,
  output logic                us_tick_o,
  output logic [US_CNT_W-1:0] us_cnt_o
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_US - 1);

  logic [PW-1:0]       pre_q;
  logic [US_CNT_W-1:0] us_q;

  assign us_tick_o = (pre_q == PRE_MAX);
  assign us_cnt_o  = us_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (clear_i) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (us_tick_o) begin
      pre_q <= '0;
      if (us_q != US_CNT_MAX) begin
        us_q <= us_q + 1'b1;
      end
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/onewire_bus_master.sv
// rtl/onewire_bus_master.sv - bit-level 1-Wire master (reset/presence, read/write slots)
// Purpose: accepts one-cycle reset / write_byte / read_byte commands with a
//          bit range and generates 1-Wire reset and slot timing on DQ.
// Ports:   clk, n_rst (async, active low); reset, write_byte, read_byte
//          commands; in_byte write data; start_bit/end_bit inclusive range;
//          wire_in DQ sense; wire_out DQ drive (0 = pull low); presence,
//          busy, out_byte (64-bit read buffer).
module onewire_bus_master
  import onewire_bus_master_pkg::*;
#(
  parameter int TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int T_RST_LOW    = DEF_T_RST_LOW,
  parameter int T_PRES_SMP   = DEF_T_PRES_SMP,
  parameter int T_RST_TOTAL  = DEF_T_RST_TOTAL,
  parameter int T_SLOT       = DEF_T_SLOT,
  parameter int T_W1_LOW     = DEF_T_W1_LOW,
  parameter int T_W0_LOW     = DEF_T_W0_LOW,
  parameter int T_RD_SMP     = DEF_T_RD_SMP
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        reset,
  input  logic        write_byte,
  input  logic        read_byte,
  input  logic [7:0]  in_byte,
  input  logic [5:0]  start_bit,
  input  logic [5:0]  end_bit,
  input  logic        wire_in,
  output logic        wire_out,
  output logic        presence,
  output logic        busy,
  output logic [63:0] out_byte
);

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    last_q, last_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          is_read_q, is_read_d;
  logic          presence_q, presence_d;
  logic [63:0]   out_byte_q, out_byte_d;
  logic          wire_out_q, wire_out_d;
  logic [1:0]    sync_q;
  logic          wire_in_s;
  logic          tmr_clear;
  logic          us_tick;
  logic [US_CNT_W-1:0] us_cnt;
  logic          advance;

  onewire_us_timer #(
    .TICKS_PER_US (TICKS_PER_US)
  ) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (tmr_clear),
    .us_tick_o (us_tick),
    .us_cnt_o  (us_cnt)
  );

  // Firing on the tick that completes microsecond t makes the transition
  // land exactly t*TICKS_PER_US clocks after the timer was cleared.
  logic at_rst_low, at_pres, at_rst_total, at_w0, at_w1, at_rd, at_slot;
  assign at_rst_low   = us_tick && (us_cnt == US_CNT_W'(T_RST_LOW - 1));
  assign at_pres      = us_tick && (us_cnt == US_CNT_W'(T_PRES_SMP - 1));
  assign at_rst_total = us_tick && (us_cnt == US_CNT_W'(T_RST_TOTAL - 1));
  assign at_w0        = us_tick && (us_cnt == US_CNT_W'(T_W0_LOW - 1));
  assign at_w1        = us_tick && (us_cnt == US_CNT_W'(T_W1_LOW - 1));
  assign at_rd        = us_tick && (us_cnt == US_CNT_W'(T_RD_SMP - 1));
  assign at_slot      = us_tick && (us_cnt == US_CNT_W'(T_SLOT - 1));

  assign wire_in_s = sync_q[1];
  assign wire_out  = wire_out_q;
  assign presence  = presence_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_byte  = out_byte_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    is_read_d  = is_read_q;
    presence_d = presence_q;
    out_byte_d = out_byte_q;
    wire_out_d = wire_out_q;
    tmr_clear  = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wire_out_d = 1'b1;
        if (reset) begin
          presence_d = 1'b0;
          wire_out_d = 1'b0;
          tmr_clear  = 1'b1;
          state_d    = ST_RST_LOW;
        end else if (write_byte || read_byte) begin
          is_read_d = !write_byte;
          idx_d     = start_bit;
          wdata_d   = in_byte;
          tmr_clear = 1'b1;
          if (start_bit > end_bit) begin
            // Empty range: NEXT sees idx == last and returns to IDLE at once.
            last_d  = start_bit;
            state_d = ST_NEXT;
          end else begin
            last_d     = end_bit;
            wire_out_d = 1'b0;
            state_d    = ST_SLOT_LOW;
          end
        end
      end

      ST_RST_LOW: begin
        if (at_rst_low) begin
          wire_out_d = 1'b1;
          tmr_clear  = 1'b1;
          state_d    = ST_RST_WAIT;
        end
      end

      ST_RST_WAIT: begin
        if (at_pres) begin
          presence_d = ~wire_in_s;
          state_d    = ST_RST_REC;
        end
      end

      ST_RST_REC: begin
        if (at_rst_total) begin
          state_d = ST_IDLE;
        end
      end

      ST_SLOT_LOW: begin
        if ((is_read_q || wdata_q[idx_q[2:0]]) ? at_w1 : at_w0) begin
          wire_out_d = 1'b1;
          state_d    = ST_SLOT_REL;
        end
      end

      ST_SLOT_REL: begin
        // Timer is not cleared at release, so samples count from slot start.
        if (is_read_q && at_rd) begin
          out_byte_d[idx_q] = wire_in_s;
        end
        // Decide the next slot here so consecutive slots abut with no gap.
        if (at_slot) begin
          advance = 1'b1;
        end
      end

      ST_NEXT: begin
        advance = 1'b1;
      end

      default: begin
        wire_out_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == last_q) begin
        wire_out_d = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        idx_d      = idx_q + 6'd1;
        wire_out_d = 1'b0;
        tmr_clear  = 1'b1;
        state_d    = ST_SLOT_LOW;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      wdata_q    <= '0;
      is_read_q  <= 1'b0;
      presence_q <= 1'b0;
      out_byte_q <= '0;
      wire_out_q <= 1'b1;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wdata_q    <= wdata_d;
      is_read_q  <= is_read_d;
      presence_q <= presence_d;
      out_byte_q <= out_byte_d;
      wire_out_q <= wire_out_d;
      sync_q     <= {sync_q[0], wire_in};
    end
  end

endmodule

// File: tb/tb_onewire_bus_master.sv
// tb/tb_onewire_bus_master.sv - directed self-checking bench for onewire_bus_master
module tb_onewire_bus_master;

  localparam int TPU = 5;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        reset, write_byte, read_byte;
  logic [7:0]  in_byte;
  logic [5:0]  start_bit, end_bit;
  logic        wire_in, wire_out, presence, busy;
  logic [63:0] out_byte;

  always #20 clk = ~clk;

  onewire_bus_master #(
    .TICKS_PER_US (TPU)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .reset      (reset),
    .write_byte (write_byte),
    .read_byte  (read_byte),
    .in_byte    (in_byte),
    .start_bit  (start_bit),
    .end_bit    (end_bit),
    .wire_in    (wire_in),
    .wire_out   (wire_out),
    .presence   (presence),
    .busy       (busy),
    .out_byte   (out_byte)
  );

  // Device model: open-drain DQ with pull-up, presence pulse, read-0 hold.
  bit  pres_en = 1'b0;
  bit  rd_en   = 1'b0;
  bit  dev_seq [128];
  int  rd_n     = 0;
  int  cyc      = 0;
  int  n_low    = 0;
  int  fall_cyc [128];
  int  low_len  [128];
  logic prev_wo = 1'b1;
  int  pres_cnt = 0;
  int  rd_cnt   = 0;
  logic dev_pull;

  assign dev_pull = (rd_cnt != 0) || (pres_cnt >= 30*TPU && pres_cnt <= 150*TPU);
  assign wire_in  = wire_out & ~dev_pull;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_wo <= wire_out;
    if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
    if (pres_cnt != 0) pres_cnt <= (pres_cnt < 200*TPU) ? pres_cnt + 1 : 0;
    if (prev_wo && !wire_out) begin
      fall_cyc[n_low] <= cyc;
      if (rd_en) begin
        if (!dev_seq[rd_n]) rd_cnt <= 30*TPU;
        rd_n <= rd_n + 1;
      end
    end
    if (!prev_wo && wire_out) begin
      low_len[n_low] <= cyc - fall_cyc[n_low];
      n_low <= n_low + 1;
      if (pres_en && (cyc - fall_cyc[n_low]) >= 400*TPU) pres_cnt <= 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command pulse and count cycles busy stays high; optionally
  // pulse read_byte once at cycle mid_at while busy.
  task automatic run_cmd(input logic r, input logic w, input logic rd,
                         input logic [7:0] b, input logic [5:0] s, input logic [5:0] e,
                         input int mid_at, output int bcyc);
    @(negedge clk);
    reset = r; write_byte = w; read_byte = rd;
    in_byte = b; start_bit = s; end_bit = e;
    @(negedge clk);
    reset = 1'b0; write_byte = 1'b0; read_byte = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 40000) begin
      bcyc++;
      if (bcyc == mid_at) begin
        start_bit = 6'd0; end_bit = 6'd7;
      end
      read_byte = (bcyc == mid_at);
      @(negedge clk);
    end
    read_byte = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int bc, base, rbase;
  logic [15:0] pat;
  logic [7:0]  wpat;

  initial begin
    n_rst = 1'b0; reset = 1'b0; write_byte = 1'b0; read_byte = 1'b0;
    in_byte = 8'h00; start_bit = 6'd0; end_bit = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_wire_out", 64'(wire_out), 64'd1);
    check("rst_presence", 64'(presence), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_out_byte", out_byte,      64'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset with device present
    pres_en = 1'b1;
    base = n_low;
    run_cmd(1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd0, -1, bc);
    check("t1_busy_cycles", 64'(bc), 64'(960*TPU));
    check("t1_low_count",   64'(n_low - base), 64'd1);
    check("t1_low_len",     64'(low_len[base]), 64'(480*TPU));
    check("t1_presence",    64'(presence), 64'd1);

    // 2: reset with no device
    pres_en = 1'b0;
    run_cmd(1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd0, -1, bc);
    check("t2_busy_cycles", 64'(bc), 64'(960*TPU));
    check("t2_presence",    64'(presence), 64'd0);

    // 3: write 0xCC, bits 0..7
    wpat = 8'hCC;
    base = n_low;
    run_cmd(1'b0, 1'b1, 1'b0, wpat, 6'd0, 6'd7, -1, bc);
    check("t3_busy_cycles", 64'(bc), 64'(8*70*TPU));
    check("t3_low_count",   64'(n_low - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_low_len%0d", i), 64'(low_len[base+i]),
            wpat[i] ? 64'(6*TPU) : 64'(60*TPU));
      if (i < 7)
        check($sformatf("t3_period%0d", i), 64'(fall_cyc[base+i+1] - fall_cyc[base+i]),
              64'(70*TPU));
    end
    check("t3_out_byte", out_byte, 64'd0);

    // 4a: read bits 0..7, device returns 0xA5
    rd_en = 1'b1;
    wpat = 8'hA5;
    rbase = rd_n;
    for (int i = 0; i < 8; i++) dev_seq[rbase+i] = wpat[i];
    run_cmd(1'b0, 1'b0, 1'b1, 8'h00, 6'd0, 6'd7, -1, bc);
    check("t4a_busy_cycles", 64'(bc), 64'(8*70*TPU));
    check("t4a_out_byte",    out_byte, 64'h0000_0000_0000_00A5);

    // 4b: read bits 48..63, device returns 0x50 then 0x05
    pat = 16'h0550;
    rbase = rd_n;
    for (int i = 0; i < 16; i++) dev_seq[rbase+i] = pat[i];
    run_cmd(1'b0, 1'b0, 1'b1, 8'h00, 6'd48, 6'd63, -1, bc);
    check("t4b_busy_cycles", 64'(bc), 64'(16*70*TPU));
    check("t4b_out_byte",    out_byte, 64'h0550_0000_0000_00A5);
    check("t4b_presence",    64'(presence), 64'd0);
    rd_en = 1'b0;

    // 5: n_rst mid write-0 low phase
    @(negedge clk);
    write_byte = 1'b1; in_byte = 8'h00; start_bit = 6'd0; end_bit = 6'd7;
    @(negedge clk);
    write_byte = 1'b0;
    repeat (20*TPU) @(negedge clk);
    check("t5_low_before", 64'(wire_out), 64'd0);
    #7 n_rst = 1'b0;
    #1;
    check("t5_wire_out", 64'(wire_out), 64'd1);
    check("t5_busy",     64'(busy),     64'd0);
    check("t5_out_byte", out_byte,      64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    base = n_low;
    run_cmd(1'b0, 1'b1, 1'b0, 8'hFF, 6'd3, 6'd3, -1, bc);
    check("t5_next_busy",    64'(bc), 64'(70*TPU));
    check("t5_next_low_len", 64'(low_len[base]), 64'(6*TPU));

    // 6: read pulse during reset is ignored; empty range gives 1-cycle busy
    base = n_low;
    run_cmd(1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd0, 100*TPU, bc);
    repeat (20) @(negedge clk);
    check("t6_busy_cycles", 64'(bc), 64'(960*TPU));
    check("t6_low_count",   64'(n_low - base), 64'd1);
    check("t6_busy_after",  64'(busy), 64'd0);
    base = n_low;
    run_cmd(1'b0, 1'b0, 1'b1, 8'h00, 6'd10, 6'd5, -1, bc);
    check("t6_empty_busy",  64'(bc), 64'd1);
    check("t6_empty_lows",  64'(n_low - base), 64'd0);
    check("t6_out_byte",    out_byte, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
